mc_native_port_arbiter: RTL and testbench

- N-port front-end arbiter for the LPDDR4 memory controller; generalises the fixed two-native-port arrangement to NUM_PORTS requesters.
- Merges native command streams into the single mc_core command port.
- Arbitration is weighted round-robin with per-port CSR weights, plus age-based starvation override.
- Registered single-entry output stage; one clock domain (system clk).

---
 rtl/mc_native_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mc_native_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_native_port_arbiter.sv
// mc_native_port_arbiter
//   Merges NUM_PORTS native command streams into the single mc_core command
//   port. Arbitration is weighted round-robin (per-port CSR weights give a
//   port that many consecutive grants) with an age-based starvation override.
//   The merged command sits in a registered single-entry output stage.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   i_port_valid      per-port command valid
//   i_port_cmd        per-port payload, port k at [k*CMD_W +: CMD_W]
//   o_port_ready      per-port accept (at most one bit set, combinational)
//   o_cmd_valid       merged command valid towards the core
//   o_cmd             merged payload
//   o_cmd_port        source port index of o_cmd
//   i_cmd_ready       core accepts o_cmd
//   i_weight_cfg      per-port weights, WEIGHT_W bits each, 0 behaves as 1
//   i_age_limit_cfg   starvation threshold, 0 disables the override
//   o_starve_flag     per-port urgent status (registered)
module mc_native_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int CMD_W     = 40,
  parameter int WEIGHT_W  = 4,
  parameter int AGE_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          i_port_valid,
  input  logic [NUM_PORTS*CMD_W-1:0]    i_port_cmd,
  output logic [NUM_PORTS-1:0]          o_port_ready,
  output logic                          o_cmd_valid,
  output logic [CMD_W-1:0]              o_cmd,
  output logic [$clog2(NUM_PORTS)-1:0]  o_cmd_port,
  input  logic                          i_cmd_ready,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] i_weight_cfg,
  input  logic [AGE_W-1:0]              i_age_limit_cfg,
  output logic [NUM_PORTS-1:0]          o_starve_flag
);

  localparam int PW = $clog2(NUM_PORTS);

  // Saturating increment for the per-port age counters.
  function automatic logic [AGE_W-1:0] sat_inc_age(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  // Credit loaded when a port newly wins: max(weight,1)-1 further grants.
  function automatic logic [WEIGHT_W-1:0] reload_credit(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? '0 : w - WEIGHT_W'(1);
  endfunction

  // Port index offs positions after base, wrapping; offs==NUM_PORTS is base.
  function automatic logic [PW-1:0] circ_idx(input logic [PW-1:0] base, input int offs);
    return PW'((int'(base) + offs) % NUM_PORTS);
  endfunction

  // Arbitration state
  logic [PW-1:0]       ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [AGE_W-1:0]    age [NUM_PORTS];

  // Output stage registers
  logic                 vld_p1;
  logic [CMD_W-1:0]     cmd_p1;
  logic [PW-1:0]        port_p1;
  logic [NUM_PORTS-1:0] starve_p1;

  // Selection signals
  logic [NUM_PORTS-1:0] urgent;
  logic                 urg_found, rr_found;
  logic [PW-1:0]        urg_sel, rr_sel, sel;
  logic                 sel_ok, sticky_pick;
  logic                 slot_free, grant;
  logic [WEIGHT_W-1:0]  weight_sel;

  // ---- Stage p0: combinational selection and handshake ----
  always_comb begin
    urgent    = '0;
    urg_found = 1'b0;
    urg_sel   = '0;
    rr_found  = 1'b0;
    rr_sel    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      urgent[k] = i_port_valid[k] && (i_age_limit_cfg != '0) && (age[k] >= i_age_limit_cfg);
    end
    // Both searches start at ptr+1 and visit ptr last.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!urg_found && urgent[circ_idx(ptr, i)]) begin
        urg_found = 1'b1;
        urg_sel   = circ_idx(ptr, i);
      end
      if (!rr_found && i_port_valid[circ_idx(ptr, i)]) begin
        rr_found = 1'b1;
        rr_sel   = circ_idx(ptr, i);
      end
    end

    sel         = '0;
    sel_ok      = 1'b0;
    sticky_pick = 1'b0;
    if (urg_found) begin
      sel    = urg_sel;
      sel_ok = 1'b1;
    end else if (i_port_valid[ptr] && (credit != '0)) begin
      sel         = ptr;
      sel_ok      = 1'b1;
      sticky_pick = 1'b1;
    end else if (rr_found) begin
      sel    = rr_sel;
      sel_ok = 1'b1;
    end

    weight_sel = i_weight_cfg[int'(sel)*WEIGHT_W +: WEIGHT_W];
    slot_free  = !vld_p1 || i_cmd_ready;
    grant      = sel_ok && slot_free && !rst;

    o_port_ready = '0;
    if (grant) o_port_ready[sel] = 1'b1;
  end

  // ---- Stage p1: output register and arbitration state update ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      cmd_p1    <= '0;
      port_p1   <= '0;
      starve_p1 <= '0;
      ptr       <= '0;
      credit    <= '0;
      for (int k = 0; k < NUM_PORTS; k++) age[k] <= '0;
    end else begin
      if (slot_free) begin
        vld_p1 <= grant;
        if (grant) begin
          cmd_p1  <= i_port_cmd[int'(sel)*CMD_W +: CMD_W];
          port_p1 <= sel;
        end
      end
      // Only a credit-backed sticky grant consumes credit; any other grant
      // (urgent, or round-robin landing back on ptr) re-arms from the CSR
      // weight, which is also where weight changes take effect.
      if (grant) begin
        if (sticky_pick) begin
          credit <= credit - WEIGHT_W'(1);
        end else begin
          ptr    <= sel;
          credit <= reload_credit(weight_sel);
        end
      end
      // Clear has priority over the saturating increment.
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!i_port_valid[k] || o_port_ready[k]) age[k] <= '0;
        else                                     age[k] <= sat_inc_age(age[k]);
      end
      starve_p1 <= urgent;
    end
  end

  assign o_cmd_valid   = vld_p1;
  assign o_cmd         = cmd_p1;
  assign o_cmd_port    = port_p1;
  assign o_starve_flag = starve_p1;

endmodule

// File: tb/tb_mc_native_port_arbiter.sv
// Testbench for mc_native_port_arbiter: expected grant order is pushed to a
// scoreboard queue as stimulus is applied and compared when the core-side
// handshake accepts each merged command.
module tb_mc_native_port_arbiter;
  localparam int NP = 4;
  localparam int CW = 40;
  localparam int WW = 4;
  localparam int AW = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NP-1:0]       i_port_valid = '0;
  logic [NP*CW-1:0]    i_port_cmd = '0;
  logic [NP-1:0]       o_port_ready;
  logic                o_cmd_valid;
  logic [CW-1:0]       o_cmd;
  logic [1:0]          o_cmd_port;
  logic                i_cmd_ready = 1'b1;
  logic [NP*WW-1:0]    i_weight_cfg = 16'h1111;
  logic [AW-1:0]       i_age_limit_cfg = '0;
  logic [NP-1:0]       o_starve_flag;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic [7:0] salt = 8'h00;
  int pat[7] = '{1, 1, 2, 2, 2, 3, 0};
  int starve_seq[11] = '{2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

  mc_native_port_arbiter #(
    .NUM_PORTS(NP), .CMD_W(CW), .WEIGHT_W(WW), .AGE_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_port_valid(i_port_valid), .i_port_cmd(i_port_cmd),
    .o_port_ready(o_port_ready),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_cmd_port(o_cmd_port),
    .i_cmd_ready(i_cmd_ready),
    .i_weight_cfg(i_weight_cfg), .i_age_limit_cfg(i_age_limit_cfg),
    .o_starve_flag(o_starve_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] pay(input int k, input logic [7:0] s);
    logic [31:0] hi;
    hi = 32'hC0DE_0000 + 32'(k) * 32'h1111;
    return {hi ^ {24'h0, s}, 8'(k)};
  endfunction

  task automatic set_salt(input logic [7:0] s);
    salt = s;
    for (int k = 0; k < NP; k++) i_port_cmd[k*CW +: CW] = pay(k, s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: pop on each accepted merged command
  always @(negedge clk) begin : mon
    int e;
    if (!rst && o_cmd_valid === 1'b1 && i_cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_port", 64'(o_cmd_port), 64'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_port", 64'(o_cmd_port), 64'(e));
        chk("sb_cmd", 64'(o_cmd), 64'(pay(e, salt)));
      end
    end
    if (!rst) chk("ready_onehot", 64'($countones(o_port_ready) <= 1), 64'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all ports requesting
    i_port_valid = 4'b1111;
    set_salt(8'h11);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 64'(o_port_ready), 64'd0);
      chk("rst_vld", 64'(o_cmd_valid), 64'd0);
      chk("rst_starve", 64'(o_starve_flag), 64'd0);
    end
    step();
    rst = 1'b0;
    exp_q.push_back(1);
    @(negedge clk);
    chk("first_grant", 64'(o_port_ready), 64'b0010);
    step();
    i_port_valid = '0;
    drain();
    @(negedge clk);
    chk("idle_vld", 64'(o_cmd_valid), 64'd0);
    step();

    // Weighted round-robin {1,2,3,1}
    i_weight_cfg = {4'd1, 4'd3, 4'd2, 4'd1};
    set_salt(8'h22);
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 7; j++) exp_q.push_back(pat[j]);
    i_port_valid = 4'b1111;
    repeat (21) step();
    i_port_valid = '0;
    drain();

    // Backpressure
    i_weight_cfg = 16'h1111;
    set_salt(8'h33);
    do_reset();
    i_port_valid = 4'b0011;
    exp_q.push_back(1);
    exp_q.push_back(0);
    step();
    i_cmd_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_vld", 64'(o_cmd_valid), 64'd1);
      chk("hold_port", 64'(o_cmd_port), 64'd1);
      chk("hold_cmd", 64'(o_cmd), 64'(pay(1, salt)));
      chk("hold_ready", 64'(o_port_ready), 64'd0);
      step();
    end
    i_cmd_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(o_port_ready), 64'b0001);
    step();
    i_port_valid = '0;
    @(negedge clk);
    chk("release_port", 64'(o_cmd_port), 64'd0);
    drain();

    // Starvation override
    i_weight_cfg = {4'd1, 4'd1, 4'd1, 4'd15};
    i_age_limit_cfg = 8'd4;
    set_salt(8'h44);
    do_reset();
    i_port_valid = 4'b0101;
    for (int j = 0; j < 11; j++) exp_q.push_back(starve_seq[j]);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk($sformatf("starve_flag_c%0d", i), 64'(o_starve_flag), (i == 7) ? 64'b0100 : 64'd0);
      if (i == 5) chk("sticky_ready", 64'(o_port_ready), 64'b0001);
      if (i == 6) chk("urgent_ready", 64'(o_port_ready), 64'b0100);
      step();
    end
    i_port_valid = '0;
    @(negedge clk);
    chk("starve_flag_c12", 64'(o_starve_flag), 64'b0100);
    drain();
    chk("starve_flag_idle", 64'(o_starve_flag), 64'd0);
    i_age_limit_cfg = '0;

    // Single requester with weight 0
    i_weight_cfg = {4'd0, 4'd1, 4'd1, 4'd1};
    set_salt(8'h55);
    do_reset();
    i_port_valid = 4'b1000;
    repeat (8) exp_q.push_back(3);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("single_ready", 64'(o_port_ready), 64'b1000);
      if (i >= 2) chk("no_bubble", 64'(o_cmd_valid), 64'd1);
      step();
    end
    i_port_valid = '0;
    drain();

    // Reset mid-stream drops the pending command and clears ptr/credit
    i_weight_cfg = {4'd1, 4'd3, 4'd2, 4'd1};
    set_salt(8'h66);
    do_reset();
    i_port_valid = 4'b1111;
    exp_q.push_back(1);
    exp_q.push_back(1);
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pending", 64'(o_cmd_port), 64'd2);
    chk("rst_mid_ready", 64'(o_port_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", 64'(o_cmd_valid), 64'd0);
    chk("rst_mid_regrant", 64'(o_port_ready), 64'b0010);
    exp_q.push_back(1);
    step();
    i_port_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
